// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined MIPS core: word type, field widths,
// fetch FSM encoding and the IF/ID pipeline register layout.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int IMM_W  = 16;
  localparam int ADDR_W = 26;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    word_t             instr;
    word_t             pcplus4;
`ifdef FETCH_PREDECODE_EN
    logic [IMM_W-1:0]  imm16;
    logic [ADDR_W-1:0] imm26;
`endif
  } ifid_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bundle, mirroring the other stage interfaces: fs is the stage side,
// tb the environment side.
interface fetch_if;
  import cpu_types_pkg::*;

  logic  halt;
  logic  id_stall;
  logic  flush;
  logic  redirect;
  word_t redirect_pc;
  logic  imemREN;
  word_t imemaddr;
  word_t imemload;
  logic  ihit;
  logic  ifid_valid;
  word_t ifid_instr;
  word_t ifid_pcplus4;

  modport fs (
    input  halt, id_stall, flush, redirect, redirect_pc, imemload, ihit,
    output imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pcplus4
  );

  modport tb (
    output halt, id_stall, flush, redirect, redirect_pc, imemload, ihit,
    input  imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pcplus4
  );
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, load fills, otherwise
// a bubble. Written against ifid_t so later pipeline registers can copy it as is.
module ifid_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  flush,
  input  logic  stall,
  input  logic  load,
  input  ifid_t din,
  output ifid_t dout
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dout <= '0;
    end else if (flush) begin
      dout.valid <= 1'b0;
    end else if (!stall) begin
      if (load) dout <= din;
      else      dout.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, icache request, one-entry skid buffer and IF/ID register.
// Define FETCH_PREDECODE_EN to add the registered ifid_imm16/ifid_imm26 outputs.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        id_stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic [31:0] imemload,
  input  logic        ihit,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pcplus4,
  output logic [1:0]  fetch_state
`ifdef FETCH_PREDECODE_EN
  , output logic [IMM_W-1:0]  ifid_imm16
  , output logic [ADDR_W-1:0] ifid_imm26
`endif
);

  fetch_state_t state, state_n;
  word_t pc, pc_n, tgt, tgt_n, skid, skid_n, skid_pc4, skid_pc4_n;
  logic  skid_valid, skid_valid_n, halt_q;
  logic  load_en;
  word_t load_instr, load_pc4, pc4;
  fetch_state_t run_state;
  ifid_t ifid_d, ifid_q;

  assign pc4       = pc + 32'd4;
  // Every entry into FETCH is diverted to HALTED once a halt has been seen.
  assign run_state = (halt_q || halt) ? HALTED : FETCH;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    tgt_n        = tgt;
    skid_n       = skid;
    skid_pc4_n   = skid_pc4;
    skid_valid_n = skid_valid;
    load_en      = 1'b0;
    load_instr   = imemload;
    load_pc4     = pc4;
    case (state)
      FETCH: begin
        if (ihit) begin
          if (redirect) begin
            pc_n    = redirect_pc;
            state_n = run_state;
          end else if (!id_stall) begin
            load_en = 1'b1;
            pc_n    = pc4;
            state_n = run_state;
          end else begin
            skid_n       = imemload;
            skid_pc4_n   = pc4;
            skid_valid_n = 1'b1;
            pc_n         = pc4;
            state_n      = HOLD;
          end
        end else if (redirect) begin
          // Keep pc on the missing address until the cache answers.
          tgt_n   = redirect_pc;
          state_n = DRAIN;
        end
      end
      HOLD: begin
        if (redirect) begin
          skid_valid_n = 1'b0;
          pc_n         = redirect_pc;
          state_n      = run_state;
        end else if (!id_stall) begin
          load_en      = 1'b1;
          load_instr   = skid;
          load_pc4     = skid_pc4;
          skid_valid_n = 1'b0;
          state_n      = run_state;
        end
      end
      DRAIN: begin
        if (ihit) begin
          pc_n    = redirect ? redirect_pc : tgt;
          state_n = run_state;
        end else if (redirect) begin
          tgt_n = redirect_pc;
        end
      end
      HALTED: begin
        if (skid_valid && !id_stall) begin
          load_en      = 1'b1;
          load_instr   = skid;
          load_pc4     = skid_pc4;
          skid_valid_n = 1'b0;
        end
      end
      default: state_n = state;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= FETCH;
      pc         <= PC_INIT;
      tgt        <= '0;
      skid       <= '0;
      skid_pc4   <= '0;
      skid_valid <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      tgt        <= tgt_n;
      skid       <= skid_n;
      skid_pc4   <= skid_pc4_n;
      skid_valid <= skid_valid_n;
      halt_q     <= halt_q | halt;
    end
  end

  always_comb begin
    ifid_d         = '0;
    ifid_d.valid   = 1'b1;
    ifid_d.instr   = load_instr;
    ifid_d.pcplus4 = load_pc4;
`ifdef FETCH_PREDECODE_EN
    ifid_d.imm16   = load_instr[IMM_W-1:0];
    ifid_d.imm26   = load_instr[ADDR_W-1:0];
`endif
  end

  ifid_reg u_ifid_reg (
    .CLK   (CLK),
    .nRST  (nRST),
    .flush (flush),
    .stall (id_stall),
    .load  (load_en),
    .din   (ifid_d),
    .dout  (ifid_q)
  );

  assign imemREN      = (state == FETCH) || (state == DRAIN);
  assign imemaddr     = pc;
  assign ifid_valid   = ifid_q.valid;
  assign ifid_instr   = ifid_q.instr;
  assign ifid_pcplus4 = ifid_q.pcplus4;
  assign fetch_state  = state;
`ifdef FETCH_PREDECODE_EN
  assign ifid_imm16   = ifid_q.imm16;
  assign ifid_imm26   = ifid_q.imm26;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level fetch model.
module tb_fetch_stage;

  localparam logic [31:0] PC_INIT = 32'h40;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        halt, id_stall, flush, redirect, ihit;
  logic [31:0] redirect_pc, imemload;
  logic        imemREN, ifid_valid;
  logic [31:0] imemaddr, ifid_instr, ifid_pcplus4;
  logic [1:0]  fetch_state;
`ifdef FETCH_PREDECODE_EN
  logic [15:0] ifid_imm16;
  logic [25:0] ifid_imm26;
`endif

  always #5 CLK = ~CLK;

  fetch_stage #(.PC_INIT(PC_INIT)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .halt         (halt),
    .id_stall     (id_stall),
    .flush        (flush),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imemREN      (imemREN),
    .imemaddr     (imemaddr),
    .imemload     (imemload),
    .ihit         (ihit),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pcplus4 (ifid_pcplus4),
    .fetch_state  (fetch_state)
`ifdef FETCH_PREDECODE_EN
    , .ifid_imm16 (ifid_imm16)
    , .ifid_imm26 (ifid_imm26)
`endif
  );

  // Model: the PC, a queue of parked words, an optional pending miss target,
  // a stopped flag, and the expected IF/ID contents.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  logic [31:0] m_pc, m_tgt, m_instr, m_pc4;
  bit          m_tgt_v, m_stopped, m_halt_seen, m_valid;
  entry_t      skid_q[$];

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc        = PC_INIT;
    m_tgt       = '0;
    m_tgt_v     = 1'b0;
    m_stopped   = 1'b0;
    m_halt_seen = 1'b0;
    m_valid     = 1'b0;
    m_instr     = '0;
    m_pc4       = '0;
    skid_q.delete();
  endtask

  function automatic bit m_req();
    return !m_stopped && (skid_q.size() == 0);
  endfunction

  task automatic model_step(input bit h, input bit st, input bit fl, input bit rd,
                            input logic [31:0] rpc, input bit hit, input logic [31:0] ld);
    bit     hs;
    bit     have_new;
    entry_t nw;
    hs       = m_halt_seen | h;
    have_new = 1'b0;
    nw       = '0;
    if (m_req()) begin
      if (m_tgt_v) begin
        if (hit) begin
          m_pc    = rd ? rpc : m_tgt;
          m_tgt_v = 1'b0;
          if (hs) m_stopped = 1'b1;
        end else if (rd) begin
          m_tgt = rpc;
        end
      end else if (hit) begin
        if (rd) begin
          m_pc = rpc;
          if (hs) m_stopped = 1'b1;
        end else if (!st) begin
          have_new = 1'b1;
          nw       = '{instr: ld, pc4: m_pc + 32'd4};
          m_pc     = m_pc + 32'd4;
          if (hs) m_stopped = 1'b1;
        end else begin
          skid_q.push_back('{instr: ld, pc4: m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
        end
      end else if (rd) begin
        m_tgt   = rpc;
        m_tgt_v = 1'b1;
      end
    end else if (skid_q.size() != 0) begin
      if (rd && !m_stopped) begin
        void'(skid_q.pop_front());
        m_pc = rpc;
        if (hs) m_stopped = 1'b1;
      end else if (!st) begin
        have_new = 1'b1;
        nw       = skid_q.pop_front();
        if (hs) m_stopped = 1'b1;
      end
    end
    m_halt_seen = hs;
    if (fl) begin
      m_valid = 1'b0;
    end else if (!st) begin
      if (have_new) begin
        m_valid = 1'b1;
        m_instr = nw.instr;
        m_pc4   = nw.pc4;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("imemREN", {31'h0, imemREN}, {31'h0, m_req()});
    check("imemaddr", imemaddr, m_pc);
    check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
    if (m_valid) begin
      check("ifid_instr", ifid_instr, m_instr);
      check("ifid_pcplus4", ifid_pcplus4, m_pc4);
`ifdef FETCH_PREDECODE_EN
      check("ifid_imm16", {16'h0, ifid_imm16}, {16'h0, m_instr[15:0]});
      check("ifid_imm26", {6'h0, ifid_imm26}, {6'h0, m_instr[25:0]});
`endif
    end
  endtask

  task automatic step(input bit h, input bit st, input bit fl, input bit rd,
                      input logic [31:0] rpc, input bit hit, input logic [31:0] ld);
    halt        = h;
    id_stall    = st;
    flush       = fl;
    redirect    = rd;
    redirect_pc = rpc;
    ihit        = hit;
    imemload    = ld;
    model_step(h, st, fl, rd, rpc, hit, ld);
    @(posedge CLK);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic do_reset();
    halt = 0; id_stall = 0; flush = 0; redirect = 0; redirect_pc = '0; ihit = 0; imemload = '0;
    nRST = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    compare_all();
  endtask

  initial begin
    int stopped_for;
    nRST = 1'b0;
    halt = 0; id_stall = 0; flush = 0; redirect = 0; redirect_pc = '0; ihit = 0; imemload = '0;
    @(negedge CLK);

    // Reset and stream
    do_reset();
    check("rst_ren", {31'h0, imemREN}, 32'h1);
    check("rst_addr", imemaddr, 32'h40);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4", ifid_pcplus4, 32'h0);
    step(0, 0, 0, 0, '0, 1, mem(m_pc));
    check("s1_addr", imemaddr, 32'h44);
    check("s1_instr", ifid_instr, 32'h1000_0040);
    check("s1_pc4", ifid_pcplus4, 32'h44);
    step(0, 0, 0, 0, '0, 1, mem(m_pc));
    check("s2_addr", imemaddr, 32'h48);
    check("s2_instr", ifid_instr, 32'h1000_0044);
    check("s2_pc4", ifid_pcplus4, 32'h48);

    // Stall mid-stream: fetch at 0x48 parks in the skid buffer
    step(0, 1, 0, 0, '0, 1, mem(m_pc));
    check("stall_ren0", {31'h0, imemREN}, 32'h0);
    check("stall_hold0", ifid_instr, 32'h1000_0044);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, '0, 0, '0);
      check("stall_ren", {31'h0, imemREN}, 32'h0);
      check("stall_hold", ifid_instr, 32'h1000_0044);
    end
    step(0, 0, 0, 0, '0, 0, '0);
    check("skid_instr", ifid_instr, 32'h1000_0048);
    check("skid_pc4", ifid_pcplus4, 32'h4C);
    check("skid_next_addr", imemaddr, 32'h4C);
    step(0, 0, 0, 0, '0, 1, mem(m_pc));

    // Redirect during a miss at 0x50
    step(0, 0, 0, 1, 32'h200, 0, '0);
    check("drain_addr0", imemaddr, 32'h50);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, '0, 0, '0);
      check("drain_addr", imemaddr, 32'h50);
      check("drain_valid", {31'h0, ifid_valid}, 32'h0);
    end
    step(0, 0, 0, 0, '0, 1, mem(32'h50));
    check("drain_tgt", imemaddr, 32'h200);
    check("drain_discard", {31'h0, ifid_valid}, 32'h0);

    // Flush together with redirect on a hit
    step(0, 0, 1, 1, 32'h80, 1, mem(m_pc));
    check("flush_valid", {31'h0, ifid_valid}, 32'h0);
    check("flush_addr", imemaddr, 32'h80);
    step(0, 0, 0, 0, '0, 1, mem(m_pc));
    check("after_flush_instr", ifid_instr, 32'h1000_0080);

    // Halt pulsed during a miss at 0x84
    step(1, 0, 0, 0, '0, 0, '0);
    check("halt_ren_miss", {31'h0, imemREN}, 32'h1);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, '0, 0, '0);
    check("halt_ren_miss2", {31'h0, imemREN}, 32'h1);
    step(0, 0, 0, 0, '0, 1, mem(m_pc));
    check("halt_ren_off", {31'h0, imemREN}, 32'h0);
    check("halt_last_instr", ifid_instr, 32'h1000_0084);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, '0, 1, mem(m_pc));
      check("halted_ren", {31'h0, imemREN}, 32'h0);
    end
    do_reset();
    check("halt_reset_addr", imemaddr, 32'h40);

    // Reset asserted during an outstanding miss
    step(0, 0, 0, 0, '0, 0, '0);
    step(0, 0, 0, 1, 32'h300, 0, '0);
    do_reset();
    check("miss_reset_addr", imemaddr, 32'h40);
    check("miss_reset_ren", {31'h0, imemREN}, 32'h1);

    // PC wrap with predecode fields
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 1, mem(m_pc));
    check("wrap_addr", imemaddr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, '0, 1, 32'h3C01_ABCD);
    check("wrap_pc4", ifid_pcplus4, 32'h0);
    check("wrap_next_addr", imemaddr, 32'h0);
    check("wrap_instr", ifid_instr, 32'h3C01_ABCD);
`ifdef FETCH_PREDECODE_EN
    check("wrap_imm16", {16'h0, ifid_imm16}, 32'h0000_ABCD);
    check("wrap_imm26", {6'h0, ifid_imm26}, 32'h0001_ABCD);
`endif

    // Random traffic
    stopped_for = 0;
    for (int n = 0; n < 3000; n++) begin
      bit          h, st, fl, rd, hit;
      logic [31:0] rpc, ld;
      h   = ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      hit = ($urandom_range(0, 1) == 0);
      rpc = $urandom() & 32'hFFFF_FFFC;
      ld  = ($urandom_range(0, 1) == 0) ? mem(m_pc) : $urandom();
      step(h, st, fl, rd, rpc, hit, ld);
      if (m_stopped) stopped_for++;
      if (stopped_for > 15 || $urandom_range(0, 499) == 0) begin
        stopped_for = 0;
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
